// File: rtl/corr_pktfifo.sv
// Per-pair byte FIFO: atomic packet admission, byte-wise drain.
// Rejected packets are counted in a saturating drop counter.
module corr_pktfifo #(
    parameter  int PKT_BYTES = 5,
    parameter  int DEPTH     = 10,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cg,
    input  logic [PKT_BYTES*8-1:0] i_pkt_data,
    input  logic                   i_pkt_valid,
    output logic [7:0]             o_data,
    output logic                   o_empty,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [CNT_W-1:0]       o_count,
    output logic [7:0]             o_nDropped
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SUM_W = CNT_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       n_drop_q, n_drop_d;

    logic             push, pop, flush;
    logic             accept, reject, do_pop;
    logic [CNT_W-1:0] space;

    // Non-power-of-2 wrap: both operands are below DEPTH, one subtract suffices.
    function automatic logic [PTR_W-1:0] wrap_add(
        input logic [PTR_W-1:0] p,
        input logic [SUM_W-1:0] n
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + n;
        if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
        return PTR_W'(s);
    endfunction

    // Event qualification, admission decision and next-state.
    always_comb begin
        push     = i_cg & i_pkt_valid;
        pop      = i_cg & i_pop;
        flush    = i_cg & i_flush;
        space    = CNT_W'(DEPTH) - count_q;
        accept   = push && !flush && (space >= CNT_W'(PKT_BYTES));
        reject   = push && !flush && !accept;
        do_pop   = pop && !flush && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        n_drop_d = n_drop_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            n_drop_d = '0;
        end else begin
            if (accept) wr_ptr_d = wrap_add(wr_ptr_q, SUM_W'(PKT_BYTES));
            if (do_pop) rd_ptr_d = wrap_add(rd_ptr_q, SUM_W'(1));
            count_d = count_q
                    + (accept ? CNT_W'(PKT_BYTES) : '0)
                    - (do_pop ? CNT_W'(1) : '0);
            if (reject && n_drop_q != 8'hFF) n_drop_d = n_drop_q + 8'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            n_drop_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            n_drop_q <= n_drop_d;
        end
    end

    // Byte storage, not reset; whole packet written in one cycle.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < PKT_BYTES; k++) begin
                mem_q[wrap_add(wr_ptr_q, SUM_W'(k))] <= i_pkt_data[k*8 +: 8];
            end
        end
    end

    // Pointer distance must always match occupancy.
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (((int'(wr_ptr_q) - int'(rd_ptr_q) + DEPTH) % DEPTH)
                    == (int'(count_q) % DEPTH));
        end
    end

    assign o_data     = mem_q[rd_ptr_q];
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;
    assign o_nDropped = n_drop_q;

endmodule

// File: tb/tb_corr_pktfifo.sv
// Scoreboard bench for corr_pktfifo (PKT_BYTES=5, DEPTH=10).
// Accepted bytes are queued by a bench model and compared on pop.
module tb_corr_pktfifo;

    localparam int PB    = 5;
    localparam int DEPTH = 10;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cg;
    logic [PB*8-1:0] pkt_data;
    logic          pkt_valid;
    logic [7:0]    data;
    logic          empty;
    logic          pop;
    logic          flush;
    logic [CW-1:0] count;
    logic [7:0]    n_dropped;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] sb_q[$];
    int         m_drop = 0;

    corr_pktfifo #(.PKT_BYTES(PB), .DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cg       (cg),
        .i_pkt_data (pkt_data),
        .i_pkt_valid(pkt_valid),
        .o_data     (data),
        .o_empty    (empty),
        .i_pop      (pop),
        .i_flush    (flush),
        .o_count    (count),
        .o_nDropped (n_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(sb_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
        chk({tag, ".drop"},  32'(n_dropped), 32'(m_drop));
    endtask

    // One clock: drive inputs, update model, check after the edge.
    task automatic step(input string tag, input logic v,
                        input logic [PB*8-1:0] d, input logic p,
                        input logic f);
        int sz;
        pkt_valid = v;
        pkt_data  = d;
        pop       = p;
        flush     = f;
        sz = sb_q.size();
        if (cg && f) begin
            sb_q.delete();
            m_drop = 0;
        end else if (cg) begin
            if (p && sz != 0) chk({tag, ".data"}, 32'(data), 32'(sb_q.pop_front()));
            if (v && (DEPTH - sz) >= PB) begin
                for (int k = 0; k < PB; k++) sb_q.push_back(d[k*8 +: 8]);
            end else if (v && m_drop < 255) begin
                m_drop++;
            end
        end
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        chk_state(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = sb_q.size();
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [63:0] r;
        rst_n = 1'b0; cg = 1'b1; pkt_data = '0;
        pkt_valid = 1'b0; pop = 1'b0; flush = 1'b0;
        #22;
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.count", 32'(count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_state("idle");
        step("pop_empty", 1'b0, '0, 1'b1, 1'b0);

        // Single packet, LSB byte first.
        step("push1", 1'b1, 40'h4433221100, 1'b0, 1'b0);
        drain("drain1");

        // Overflow and saturation.
        step("bb0", 1'b1, 40'hA4A3A2A1A0, 1'b0, 1'b0);
        step("bb1", 1'b1, 40'hB4B3B2B1B0, 1'b0, 1'b0);
        step("bb2", 1'b1, 40'hC4C3C2C1C0, 1'b0, 1'b0);
        chk("bb.count10", 32'(count), 32'd10);
        chk("bb.drop1", 32'(n_dropped), 32'd1);
        for (int i = 0; i < 300; i++) step("sat", 1'b1, 40'(i), 1'b0, 1'b0);
        chk("sat.drop", 32'(n_dropped), 32'd255);

        // Clock gate off: nothing moves.
        cg = 1'b0;
        step("cg0", 1'b1, 40'h1, 1'b1, 1'b1);
        cg = 1'b1;

        // count=6, push+pop same cycle: push rejected on pre-pop space.
        step("fl0", 1'b0, '0, 1'b0, 1'b1);
        step("c6a", 1'b1, 40'h1413121110, 1'b0, 1'b0);
        step("c6b", 1'b1, 40'h2423222120, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("c6pop", 1'b0, '0, 1'b1, 1'b0);
        step("c6pp", 1'b1, 40'h3433323130, 1'b1, 1'b0);
        chk("c6.count5", 32'(count), 32'd5);
        chk("c6.drop1", 32'(n_dropped), 32'd1);

        // Wrap: read pointer straddles 9->0 across packets.
        step("fl1", 1'b0, '0, 1'b0, 1'b1);
        step("wA1", 1'b1, 40'h5453525150, 1'b0, 1'b0);
        step("wA2", 1'b1, 40'h5958575655, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("wpop8", 1'b0, '0, 1'b1, 1'b0);
        step("wB", 1'b1, 40'h6463626160, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("wpop3", 1'b0, '0, 1'b1, 1'b0);
        step("wC", 1'b1, 40'h7473727170, 1'b0, 1'b0);
        drain("wdrain");

        // Flush with push at count=7.
        step("f7a", 1'b1, 40'h8483828180, 1'b0, 1'b0);
        step("f7b", 1'b1, 40'h8988878685, 1'b0, 1'b0);
        step("f7c", 1'b1, 40'h9999999999, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("f7pop", 1'b0, '0, 1'b1, 1'b0);
        chk("f7.count", 32'(count), 32'd7);
        step("f7fl", 1'b1, 40'hAAAAAAAAAA, 1'b1, 1'b1);
        chk("f7.drop0", 32'(n_dropped), 32'd0);

        // Random mix against the model.
        for (int i = 0; i < 400; i++) begin
            r = {$urandom(), $urandom()};
            step("rnd", 1'($urandom_range(0, 2) == 0), r[39:0],
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset mid-drain.
        step("ra", 1'b1, 40'hC0C0C0C0C0, 1'b0, 1'b1);
        step("rb", 1'b1, 40'hD4D3D2D1D0, 1'b0, 1'b0);
        step("rc", 1'b1, 40'hE4E3E2E1E0, 1'b0, 1'b0);
        step("rd", 1'b1, 40'hF4F3F2F1F0, 1'b0, 1'b0);
        step("re", 1'b0, '0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        m_drop = 0;
        chk_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_state("post_rst");
        step("pr_push", 1'b1, 40'h0102030405, 1'b0, 1'b0);
        drain("pr_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
